// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler feeding single and two-byte requests to a UART transmitter
// Launches one byte at a time and waits for the transmitter BUSY handshake, with a launch timeout.
module uart_tx_sched #(
    parameter int DATAWIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_a,
    input  logic [DATAWIDTH-1:0]   i_data_a,
    input  logic                   i_req_b,
    input  logic [2*DATAWIDTH-1:0] i_data_b,
    input  logic                   i_tx_busy,
    output logic                   o_ack_a,
    output logic                   o_ack_b,
    output logic [DATAWIDTH-1:0]   o_tx_p_data,
    output logic                   o_tx_data_valid,
    output logic                   o_sched_busy,
    output logic                   o_to_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_rem;
    logic                   r_last_b;
    logic [2*DATAWIDTH-1:0] r_hold;
    logic [DATAWIDTH-1:0]   r_tx_p_data;
    logic                   r_valid;
    logic                   r_ack_a;
    logic                   r_ack_b;
    logic                   r_to_err;

    state_t                 w_state;
    logic [CW-1:0]          w_cnt;
    logic                   w_rem;
    logic                   w_last_b;
    logic [2*DATAWIDTH-1:0] w_hold;
    logic [DATAWIDTH-1:0]   w_tx_p_data;
    logic                   w_valid;
    logic                   w_ack_a;
    logic                   w_ack_b;
    logic                   w_to_err;
    logic                   w_grant_a;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= 1'b0;
            r_last_b    <= 1'b1;
            r_hold      <= '0;
            r_tx_p_data <= '0;
            r_valid     <= 1'b0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_to_err    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_rem       <= w_rem;
            r_last_b    <= w_last_b;
            r_hold      <= w_hold;
            r_tx_p_data <= w_tx_p_data;
            r_valid     <= w_valid;
            r_ack_a     <= w_ack_a;
            r_ack_b     <= w_ack_b;
            r_to_err    <= w_to_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_rem       = r_rem;
        w_last_b    = r_last_b;
        w_hold      = r_hold;
        w_tx_p_data = r_tx_p_data;
        w_valid     = 1'b0;
        w_ack_a     = 1'b0;
        w_ack_b     = 1'b0;
        w_to_err    = 1'b0;
        // A wins when alone, or on a tie when B was served last
        w_grant_a   = i_req_a && (!i_req_b || r_last_b);

        case (r_state)
            S_IDLE: begin
                if (!i_tx_busy && (i_req_a || i_req_b)) begin
                    w_valid = 1'b1;
                    w_cnt   = '0;
                    w_state = S_WAIT_HI;
                    if (w_grant_a) begin
                        w_ack_a     = 1'b1;
                        w_tx_p_data = i_data_a;
                        w_rem       = 1'b0;
                        w_last_b    = 1'b0;
                    end else begin
                        w_ack_b     = 1'b1;
                        w_hold      = i_data_b;
                        w_tx_p_data = i_data_b[DATAWIDTH-1:0];
                        w_rem       = 1'b1;
                        w_last_b    = 1'b1;
                    end
                end
            end
            S_WAIT_HI: begin
                if (i_tx_busy) begin
                    w_state = S_WAIT_LO;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    // transmitter never acknowledged: drop the rest of the word
                    w_to_err = 1'b1;
                    w_rem    = 1'b0;
                    w_state  = S_IDLE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!i_tx_busy) begin
                    if (r_rem) begin
                        w_tx_p_data = r_hold[2*DATAWIDTH-1:DATAWIDTH];
                        w_valid     = 1'b1;
                        w_rem       = 1'b0;
                        w_cnt       = '0;
                        w_state     = S_WAIT_HI;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_ack_a         = r_ack_a;
    assign o_ack_b         = r_ack_b;
    assign o_tx_p_data     = r_tx_p_data;
    assign o_tx_data_valid = r_valid;
    assign o_to_err        = r_to_err;
    assign o_sched_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a;
    logic [DW-1:0] data_a;
    logic          req_b;
    logic [2*DW-1:0] data_b;
    logic          busy;
    logic          ack_a;
    logic          ack_b;
    logic [DW-1:0] p_data;
    logic          dvalid;
    logic          sbusy;
    logic          to_err;

    logic tx_b       = 1'b0;
    logic force_busy = 1'b0;
    bit   tx_stuck   = 1'b0;
    bit   rand_tx    = 1'b0;
    bit   auto_req   = 1'b0;
    int   tx_wait    = -1;
    int   tx_left    = 0;

    int n_chk  = 0;
    int n_pass = 0;

    assign busy = tx_b | force_busy;

    uart_tx_sched #(.DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_a(req_a), .i_data_a(data_a),
        .i_req_b(req_b), .i_data_b(data_b),
        .i_tx_busy(busy),
        .o_ack_a(ack_a), .o_ack_b(ack_b),
        .o_tx_p_data(p_data), .o_tx_data_valid(dvalid),
        .o_sched_busy(sbusy), .o_to_err(to_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a grant turns into a queue of bytes; each byte is sent, then
    // the transmitter must raise BUSY within TO cycles and later drop it.
    bit            m_act, m_rise, m_last_b;
    int            m_age;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_data;
    bit            e_ack_a, e_ack_b, e_valid, e_err;

    task automatic m_launch(input logic [DW-1:0] b);
        e_valid = 1; m_data = b; m_act = 1; m_rise = 1; m_age = 0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        e_ack_a = 0; e_ack_b = 0; e_valid = 0; e_err = 0;
        if (rst) begin
            m_act = 0; m_rise = 0; m_last_b = 1; m_age = 0; m_q.delete(); m_data = '0;
        end else if (!m_act) begin
            if (!busy && (req_a || req_b)) begin
                if (req_a && (!req_b || m_last_b)) begin
                    e_ack_a = 1; m_last_b = 0; m_q.delete(); m_launch(data_a);
                end else begin
                    e_ack_b = 1; m_last_b = 1; m_q.delete(); m_q.push_back(data_b[2*DW-1:DW]);
                    m_launch(data_b[DW-1:0]);
                end
            end
        end else if (m_rise) begin
            if (busy) m_rise = 0;
            else if (m_age == TO - 1) begin e_err = 1; m_q.delete(); m_act = 0; end
            else m_age++;
        end else if (!busy) begin
            if (m_q.size() > 0) m_launch(m_q.pop_front());
            else m_act = 0;
        end
    end

    logic prev_valid = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("ack_a", ack_a, e_ack_a);
            chk("ack_b", ack_b, e_ack_b);
            chk("tx_data_valid", dvalid, e_valid);
            chk("to_err", to_err, e_err);
            chk("sched_busy", sbusy, m_act);
            chk("tx_p_data", p_data, m_data);
            chk("ack_mutex", ack_a & ack_b, 0);
            chk("valid_back_to_back", dvalid & prev_valid, 0);
        end
        prev_valid = dvalid;
    end

    task automatic tick();
        @(negedge clk);
        if (dvalid) begin
            if (tx_stuck || (rand_tx && $urandom_range(0, 7) == 0)) tx_wait = -1;
            else begin
                tx_wait = rand_tx ? int'($urandom_range(0, 2)) : 0;
                tx_left = rand_tx ? int'($urandom_range(1, 6)) : 10;
            end
        end
        if (tx_wait == 0) begin tx_b = 1; tx_wait = -1; end
        else if (tx_wait > 0) tx_wait--;
        else if (tx_b) begin tx_left--; if (tx_left <= 0) tx_b = 0; end
        if (auto_req) begin
            if (req_a && ack_a) req_a = 0;
            else if (req_a && $urandom_range(0, 15) == 0) req_a = 0;
            else if (!req_a && $urandom_range(0, 3) == 0) begin req_a = 1; data_a = DW'($urandom); end
            if (req_b && ack_b) req_b = 0;
            else if (req_b && $urandom_range(0, 15) == 0) req_b = 0;
            else if (!req_b && $urandom_range(0, 3) == 0) begin req_b = 1; data_b = (2*DW)'($urandom); end
        end
    endtask

    task automatic do_reset();
        rst = 1; req_a = 0; req_b = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sbusy || tx_b) && k < 100) begin tick(); k++; end
        chk("wait_idle_bound", k < 100, 1);
    endtask

    initial begin
        int k, nv, na, ne;
        logic [DW-1:0] last_byte;
        string order;
        rst = 1; req_a = 0; req_b = 0; data_a = '0; data_b = '0;
        tick(); tick();
        chk("rst_ack_a", ack_a, 0);
        chk("rst_ack_b", ack_b, 0);
        chk("rst_valid", dvalid, 0);
        chk("rst_to_err", to_err, 0);
        chk("rst_p_data", p_data, 0);
        chk("rst_sched_busy", sbusy, 0);
        rst = 0;
        tick();

        // single A byte, transmitter busy for 10 cycles
        req_a = 1; data_a = 8'h5A;
        tick();
        chk("t1_ack_a", ack_a, 1);
        chk("t1_valid", dvalid, 1);
        chk("t1_data", p_data, 8'h5A);
        req_a = 0;
        k = 0;
        while (sbusy && k < 40) begin tick(); k++; end
        chk("t1_idle_after", k, 11);
        wait_idle();

        // B word: low byte first, then high byte with no second ACK
        req_b = 1; data_b = 16'hBEEF;
        tick();
        chk("t2_ack_b", ack_b, 1);
        chk("t2_low_byte", p_data, 8'hEF);
        req_b = 0;
        k = 0; nv = 0; na = 0; last_byte = '0;
        while (sbusy && k < 60) begin
            tick(); k++;
            if (dvalid) begin nv++; last_byte = p_data; end
            if (ack_a || ack_b) na++;
        end
        chk("t2_second_launches", nv, 1);
        chk("t2_high_byte", last_byte, 8'hBE);
        chk("t2_extra_acks", na, 0);
        wait_idle();

        // tie after reset: strict alternation starting with A
        do_reset();
        req_a = 1; data_a = 8'hA1; req_b = 1; data_b = 16'hB2B3;
        order = ""; k = 0;
        while (order.len() < 4 && k < 400) begin
            tick(); k++;
            if (!req_a) req_a = 1;
            if (!req_b) req_b = 1;
            if (ack_a) begin order = {order, "A"}; req_a = 0; end
            if (ack_b) begin order = {order, "B"}; req_b = 0; end
        end
        n_chk++;
        if (order == "ABAB") n_pass++;
        else $display("FAIL t3_rr_order: got %s want ABAB", order);
        req_a = 0; req_b = 0;
        wait_idle();

        // BUSY never rises: timeout 16 cycles after launch, high byte dropped
        tx_stuck = 1;
        req_b = 1; data_b = 16'h1234;
        tick();
        chk("t4_low_byte", p_data, 8'h34);
        req_b = 0;
        k = 0; nv = 0;
        while (!to_err && k < 40) begin tick(); k++; if (dvalid) nv++; end
        chk("t4_err_latency", k, 16);
        ne = 0;
        repeat (8) begin tick(); if (dvalid) nv++; if (to_err) ne++; end
        chk("t4_single_err", ne, 0);
        chk("t4_no_high_byte", nv, 0);
        chk("t4_idle", sbusy, 0);
        tx_stuck = 0;
        wait_idle();

        // reset while waiting for the low byte to finish
        req_b = 1; data_b = 16'hBEEF;
        tick();
        req_b = 0;
        tick(); tick();
        chk("t5_in_frame", sbusy, 1);
        rst = 1;
        #1;
        chk("t5_rst_valid", dvalid, 0);
        chk("t5_rst_data", p_data, 0);
        chk("t5_rst_sched_busy", sbusy, 0);
        tick(); tick();
        rst = 0;
        nv = 0;
        repeat (30) begin tick(); if (dvalid) nv++; end
        chk("t5_no_high_byte", nv, 0);
        wait_idle();

        // transmitter busy while idle holds off the grant
        force_busy = 1;
        req_a = 1; data_a = 8'h77;
        na = 0;
        repeat (6) begin tick(); if (ack_a || ack_b || dvalid) na++; end
        chk("t6_held_off", na, 0);
        force_busy = 0;
        tick();
        chk("t6_ack_a", ack_a, 1);
        chk("t6_data", p_data, 8'h77);
        req_a = 0;
        wait_idle();

        // randomized traffic, including withdrawals and random timeouts
        auto_req = 1; rand_tx = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin rst = 1; tick(); tick(); rst = 0; end
            tick();
        end
        auto_req = 0; req_a = 0; req_b = 0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DATAWIDTH, default 8, sets the width of one UART byte.
REQ-002 Parameter TIMEOUT, default 16, sets the max cycles spent waiting for TX_BUSY to rise after a launch.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ_A  input  1  requester A (register-read path): one byte pending, level, held until ACK_A.
REQ-006 DATA_A  input  DATAWIDTH  requester A byte; stable while REQ_A=1.
REQ-007 REQ_B  input  1  requester B (ALU path): two-byte word pending, level, held until ACK_B.
REQ-008 DATA_B  input  2*DATAWIDTH  requester B word; stable while REQ_B=1.
REQ-009 ACK_A / ACK_B  output  1 each  one-cycle pulse marking the accepted request.
REQ-010 TX_BUSY  input  1  BUSY from the UART transmitter.
REQ-011 TX_P_DATA  output  DATAWIDTH  byte to the transmitter P_DATA.
REQ-012 TX_DATA_VALID  output  1  one-cycle launch strobe to the transmitter DATA_VALID.
REQ-013 SCHED_BUSY  output  1  high whenever the state is not IDLE.
REQ-014 TO_ERR  output  1  one-cycle pulse on launch timeout.

Function
REQ-015 States SHALL be IDLE, WAIT_HI, WAIT_LO; all outputs SHALL be registered except SCHED_BUSY, which is decoded from state.
REQ-016 IDLE, TX_BUSY=0, at least one REQ: grant per round-robin, assert ACK of the winner, load TX_P_DATA, pulse TX_DATA_VALID, go to WAIT_HI (all at one edge).
REQ-017 Round-robin: with both REQ high, the requester not granted last wins; a sole requester always wins; the last-grant register SHALL reset to B, so A wins the first tie.
REQ-018 Grant A: TX_P_DATA=DATA_A; bytes remaining after this launch = 0.
REQ-019 Grant B: the full DATA_B word SHALL be latched into a hold register; TX_P_DATA=DATA_B[DATAWIDTH-1:0] (low byte first); bytes remaining = 1.
REQ-020 IDLE with TX_BUSY=1: no grant; requests wait.
REQ-021 WAIT_HI: timeout counter starts at 0 on entry and increments each cycle. TX_BUSY=1 -> WAIT_LO. Counter reaching TIMEOUT-1 with TX_BUSY still 0 -> pulse TO_ERR, discard any remaining byte, go to IDLE.
REQ-022 WAIT_LO, TX_BUSY=0, bytes remaining=1: TX_P_DATA = hold[2*DATAWIDTH-1:DATAWIDTH], pulse TX_DATA_VALID, clear remaining, go to WAIT_HI with no new ACK.
REQ-023 WAIT_LO, TX_BUSY=0, bytes remaining=0 -> IDLE; the next grant is possible at the following edge (earliest one cycle after IDLE entry).
REQ-024 TX_DATA_VALID SHALL never be high for two consecutive cycles, and never while TX_BUSY=1 was sampled at the launching edge.
REQ-025 TX_P_DATA SHALL hold its value between launches.
REQ-026 The requester SHALL drop REQ within one cycle of ACK; a REQ still high at the next IDLE decision is a new request.
REQ-027 REQ deassertion while not granted SHALL withdraw the request silently.
REQ-028 ACK_A and ACK_B SHALL be mutually exclusive.

Reset
REQ-029 RST=1 SHALL immediately force: state IDLE; ACK_A, ACK_B, TX_DATA_VALID and TO_ERR = 0; TX_P_DATA = 0; hold register = 0; counter = 0; remaining = 0; last-grant = B.
REQ-030 Reset mid-frame SHALL discard any pending high byte; no launch occurs in the first edge after RST falls unless a REQ is high with TX_BUSY=0.

Verification
REQ-031 REQ_A=1, DATA_A=0x5A, TX_BUSY=0 -> next edge: ACK_A=1, TX_DATA_VALID=1, TX_P_DATA=0x5A; model BUSY high 10 cycles then low -> IDLE, SCHED_BUSY=0.
REQ-032 REQ_B=1, DATA_B=0xBEEF -> launch 0xEF, wait for TX_BUSY to rise then fall, then launch 0xBE with a single ACK_B; exactly two TX_DATA_VALID pulses.
REQ-033 REQ_A and REQ_B high together after reset, re-asserted after each ACK -> grant order A, B, A, B.
REQ-034 Launch with TX_BUSY stuck 0, TIMEOUT=16 -> TO_ERR pulses once, 16 cycles after TX_DATA_VALID; back to IDLE; for a B word the high byte is never sent.
REQ-035 RST asserted in WAIT_LO between the 0xEF and 0xBE bytes -> outputs zero asynchronously; 0xBE is never launched.
REQ-036 TX_BUSY=1 in IDLE with REQ_A=1 -> no ACK until TX_BUSY=0, then grant on the next edge.
